alu_mul_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/mul_shift_add_dp.sv | 69 ++++++
 rtl/alu_mul_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU sequencer: op codes,
// sequencer state encoding and the default datapath width.
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_MUL = 3'b101;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'b00,
        SEQ_MUL  = 2'b01,
        SEQ_DONE = 2'b10
    } seq_state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Iterative shift-add multiply datapath. A load captures the operands and
// clears the accumulator; each step adds the multiplicand when the current
// multiplier LSB is set, then shifts both operands. The next accumulator
// value is exported so the final step can be registered directly as the result.
module mul_shift_add_dp
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] acc_next_o
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_step_s;

    // Partial-product accumulation for the current step (wraps mod 2^WIDTH)
    always_comb begin
        acc_step_s = acc_q;
        if (mplier_q[0]) begin
            acc_step_s = acc_q + mcand_q;
        end else begin
            acc_step_s = acc_q;
        end
    end

    assign acc_next_o = acc_step_s;

    // Next-state selection: load has priority over step, otherwise hold
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (load_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = {WIDTH{1'b0}};
        end else if (step_i) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_step_s;
        end else begin
            mcand_d  = mcand_q;
            mplier_d = mplier_q;
            acc_d    = acc_q;
        end
    end

    // Operand and accumulator registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Execute-stage ALU wrapper with a start/busy/done handshake. Logic ops,
// add/sub and set-less-than finish in one cycle; multiply iterates WIDTH
// shift-add steps so no wide combinational multiplier sits in EX.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;

    logic             load_s;
    logic             step_s;
    logic [WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0] alu_res_s;
    logic [WIDTH-1:0] diff_s;
    logic             ovf_s;
    logic             slt_s;

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_mul_dp (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load_s),
        .step_i     (step_s),
        .a_i        (data1_i),
        .b_i        (data2_i),
        .acc_next_o (acc_next_s)
    );

    // Single-cycle op mux; SLT uses the overflow-corrected sign of A-B
    always_comb begin
        diff_s    = data1_i - data2_i;
        ovf_s     = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) &&
                    (diff_s[WIDTH-1] != data1_i[WIDTH-1]);
        slt_s     = ovf_s ? ~data1_i[WIDTH-1] : data1_i[WIDTH-1];
        alu_res_s = {WIDTH{1'b0}};
        case (ALUCtrl_i)
            ALU_AND: alu_res_s = data1_i & data2_i;
            ALU_OR:  alu_res_s = data1_i | data2_i;
            ALU_ADD: alu_res_s = data1_i + data2_i;
            ALU_SUB: alu_res_s = diff_s;
            ALU_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, slt_s};
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Sequencer next state: accept in IDLE/DONE, iterate in MUL, one-cycle done pulse
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        data_d  = data_q;
        zero_d  = zero_q;
        load_s  = 1'b0;
        step_s  = 1'b0;
        case (state_q)
            SEQ_IDLE, SEQ_DONE: begin
                if (start_i) begin
                    if (ALUCtrl_i == ALU_MUL) begin
                        load_s  = 1'b1;
                        cnt_d   = {CNT_W{1'b0}};
                        busy_d  = 1'b1;
                        state_d = SEQ_MUL;
                    end else begin
                        data_d  = alu_res_s;
                        zero_d  = (alu_res_s == {WIDTH{1'b0}});
                        done_d  = 1'b1;
                        state_d = SEQ_DONE;
                    end
                end else begin
                    state_d = SEQ_IDLE;
                end
            end
            SEQ_MUL: begin
                step_s = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    data_d  = acc_next_s;
                    zero_d  = (acc_next_s == {WIDTH{1'b0}});
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = SEQ_DONE;
                end else begin
                    state_d = SEQ_MUL;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // Sequencer and output registers; reset overrides any start in the same cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign data_o = data_q;
    assign Zero_o = zero_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed self-checking bench for alu_mul_sequencer. Expected results are
// pushed to a scoreboard when an op is issued and popped on done_o.
module tb_alu_mul_sequencer;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    ctrl;
    logic [W-1:0]  d1;
    logic [W-1:0]  d2;
    logic          busy;
    logic          done;
    logic [W-1:0]  dout;
    logic          zero;

    typedef struct packed {
        logic [W-1:0] data;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    alu_mul_sequencer #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .ALUCtrl_i (ctrl),
        .data1_i   (d1),
        .data2_i   (d2),
        .busy_o    (busy),
        .done_o    (done),
        .data_o    (dout),
        .Zero_o    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        case (op)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: return a + b;
            3'b110: return a - b;
            3'b111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b101: begin
                prod = {32'd0, a} * {32'd0, b};
                return prod[W-1:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.data = model(op, a, b);
        e.zero = (e.data == 32'd0);
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, 64'(dout), 64'(e.data));
            check({tag, "_zero"}, 64'(zero), 64'(e.zero));
        end else begin
            e = '0;
        end
    endtask

    // Issue one op, then watch cycles 1..N; optional start glitch or reset injection.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_lat, input int glitch_k, input int rst_k);
        bit seen;
        bit is_mul;
        seen   = 1'b0;
        is_mul = (op == 3'b101);
        @(negedge clk);
        start = 1'b1; ctrl = op; d1 = a; d2 = b;
        push_exp(op, a, b);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (rst_k != 0 && k == rst_k + 1) begin
                rst = 1'b0;
                check({tag, "_rst_busy"}, 64'(busy), 64'd0);
                check({tag, "_rst_done"}, 64'(done), 64'd0);
                check({tag, "_rst_data"}, 64'(dout), 64'd0);
                check({tag, "_rst_zero"}, 64'(zero), 64'd0);
                sb.delete();
                seen = 1'b1;
            end else if (done) begin
                check({tag, "_latency"}, 64'(k), 64'(exp_lat));
                check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
                pop_check(tag);
                seen = 1'b1;
            end else begin
                check({tag, "_busy"}, 64'(busy), 64'(is_mul && k <= W));
            end
            if (seen) break;
            if (k == glitch_k) begin
                start = 1'b1; ctrl = 3'b010; d1 = 32'd1; d2 = 32'd1;
            end else if (k == rst_k) begin
                rst = 1'b1;
            end
        end
        if (!seen) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ctrl = 3'b000; d1 = 32'd0; d2 = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_data", 64'(dout), 64'd0);
        check("reset_zero", 64'(zero), 64'd0);
        rst = 1'b0;

        run_op("add_5_3", 3'b010, 32'h00000005, 32'h00000003, 1, 0, 0);

        // Back-to-back SUB then SLT: second start accepted while in DONE
        @(negedge clk);
        start = 1'b1; ctrl = 3'b110; d1 = 32'd5; d2 = 32'd5;
        push_exp(3'b110, 32'd5, 32'd5);
        @(negedge clk);
        check("b2b_sub_done", 64'(done), 64'd1);
        pop_check("b2b_sub");
        ctrl = 3'b111; d1 = 32'h80000000; d2 = 32'h00000001;
        push_exp(3'b111, 32'h80000000, 32'h00000001);
        @(negedge clk);
        start = 1'b0;
        check("b2b_slt_done", 64'(done), 64'd1);
        pop_check("b2b_slt");
        @(negedge clk);
        check("b2b_done_drop", 64'(done), 64'd0);

        run_op("slt_max_m1", 3'b111, 32'h7FFFFFFF, 32'hFFFFFFFF, 1, 0, 0);
        run_op("slt_1_2",    3'b111, 32'h00000001, 32'h00000002, 1, 0, 0);
        run_op("and",        3'b000, 32'hF0F0A5A5, 32'h0FF0FF00, 1, 0, 0);
        run_op("or",         3'b001, 32'hF0000001, 32'h0000F000, 1, 0, 0);
        run_op("add_wrap",   3'b010, 32'hFFFFFFFF, 32'h00000002, 1, 0, 0);
        run_op("mul_7_6",    3'b101, 32'h00000007, 32'h00000006, W + 1, 0, 0);
        run_op("mul_m1_m1",  3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, W + 1, 0, 0);
        run_op("mul_glitch", 3'b101, 32'h00012345, 32'h0000A6B7, W + 1, 5, 0);
        run_op("mul_zero",   3'b101, 32'h00010000, 32'h00010000, W + 1, 0, 0);
        run_op("mul_rst",    3'b101, 32'h00000009, 32'h00000009, 0, 0, 10);
        run_op("add_after_rst", 3'b010, 32'h00000001, 32'h00000001, 1, 0, 0);
        run_op("undef_011",  3'b011, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0);
        run_op("undef_100",  3'b100, 32'h12345678, 32'h00000001, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
